// File: rtl/i8out_pack.sv
// Output packer for the int8 conv datapath: captures NP-lane result groups
// into a small FIFO and drains them as single-byte writes under backpressure.
module i8out_pack #(
  parameter int NP    = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            acvalid,
  input  logic [NP*8-1:0] accd,
  input  logic [NP-1:0]   lane_en,
  input  logic [AW-1:0]   oaddr,
  input  logic [15:0]     ostride,
  input  logic            mem_rdy,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_adr,
  output logic [7:0]      mem_wdata,
  output logic            busy,
  output logic            ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic {IDLE, WRITE} st_t;

  logic [NP-1:0][7:0] dat_q [DEPTH];
  logic [NP-1:0]      en_q  [DEPTH];
  logic [AW-1:0]      adr_q [DEPTH];

  logic [PW-1:0] wp_q, rp_q, rp_nx, sel_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  st_t           st_q, st_d;
  logic [LW-1:0] lane_q, sel_lane, cur_lane, nx_lane;
  logic          wen_q, wen_d, busy_q, busy_d, ovf_q;
  logic [AW-1:0] madr_q, madr_d;
  logic [7:0]    mdat_q, mdat_d;
  logic          push, pop, full, load, cur_hit, nx_hit;
  logic [31:0]   prod;
  int            start;

  // Lowest enabled lane at or above 'from'; MSB flags a hit.
  function automatic logic [LW:0] first_en(input logic [NP-1:0] en, input int from);
    logic [LW:0] r;
    r = '0;
    for (int k = NP - 1; k >= 0; k--)
      if (en[k] && k >= from) r = {1'b1, LW'(k)};
    return r;
  endfunction

  assign rp_nx = rp_q + PW'(1);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    start = 0;
    if (st_q == WRITE) start = int'(lane_q) + 1;
  end

  assign {cur_hit, cur_lane} = first_en(en_q[rp_q], start);
  assign {nx_hit, nx_lane}   = first_en(en_q[rp_nx], 0);

  always_comb begin
    st_d     = st_q;
    pop      = 1'b0;
    load     = 1'b0;
    sel_ptr  = rp_q;
    sel_lane = cur_lane;
    case (st_q)
      IDLE: if (cnt_q != '0) begin
        if (cur_hit) begin
          st_d = WRITE;
          load = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      WRITE: if (mem_rdy) begin
        if (cur_hit) begin
          load = 1'b1;
        end else begin
          // Last lane retired: chain straight into the next entry when it has work.
          pop = 1'b1;
          if (cnt_q > CW'(1) && nx_hit) begin
            load     = 1'b1;
            sel_ptr  = rp_nx;
            sel_lane = nx_lane;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign prod   = {{(32-LW){1'b0}}, sel_lane} * {16'b0, ostride};
  assign madr_d = load ? adr_q[sel_ptr] + AW'(prod) : madr_q;
  assign mdat_d = load ? dat_q[sel_ptr][sel_lane] : mdat_q;
  assign wen_d  = (st_d == WRITE);
  assign push   = acvalid && (!full || pop);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
  assign busy_d = (cnt_d != '0) || wen_d;

  always_ff @(posedge clk) begin
    if (!xreset) begin
      st_q   <= IDLE;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
      wen_q  <= 1'b0;
      madr_q <= '0;
      mdat_q <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      madr_q <= madr_d;
      mdat_q <= mdat_d;
      busy_q <= busy_d;
      if (load) lane_q <= sel_lane;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_nx;
      if (acvalid && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wp_q] <= accd;
      en_q[wp_q]  <= lane_en;
      adr_q[wp_q] <= oaddr;
    end
  end

  assign mem_wen   = wen_q;
  assign mem_adr   = madr_q;
  assign mem_wdata = mdat_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule
